mbist_fail_log: RTL and testbench

Downstream fail-address logger for the MBIST controller. Watches the controller's `error`, `address`, `memtype` and status outputs, captures each failing address (masked to the selected memory's address width) into a small show-ahead FIFO, and keeps a saturating fail counter. Sits between `mbist` and the chip-level diagnostic read-out, so failing addresses can be drained after `complete` or `force_terminate`.

---
 rtl/mbist_fail_log.sv | 187 ++++++++++++++++++
 tb/tb_mbist_fail_log.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_fail_log.sv
// mbist_fail_log: captures MBIST fail addresses into a show-ahead FIFO and
// keeps a saturating fail counter per log session (IDLE -> LOGGING -> DONE).
// Optional feature macro: MBIST_FAIL_LOG_DEDUP_EN -- suppresses pushing an
// address identical to the last one pushed in the current session.
module mbist_fail_log #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_mode,
    input  logic [4:0]            memtype,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  error,
    input  logic                  complete,
    input  logic                  force_terminate,
    input  logic                  fail_ready,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow,
    output logic                  log_done
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    typedef enum logic [1:0] {IDLE, LOGGING, DONE} state_t;

    state_t                state_q, state_d;
    logic                  test_mode_q, test_mode_d;
    logic                  error_q, error_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
    logic                  overflow_q, overflow_d;
    logic                  log_done_q, log_done_d;

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    logic [31:0]           keep_msb;
    logic [ADDR_WIDTH-1:0] addr_mask;
    logic [ADDR_WIDTH-1:0] masked_addr;
    logic                  empty_w, full_w;
    logic                  session_start, fail_event, dup;
    logic                  do_pop, do_push, do_drop;

    // memtype[1:0] does not affect the address width
    logic unused_memtype_lo;
    assign unused_memtype_lo = ^memtype[1:0];

    // Highest kept address bit is 8 + memtype[4:2]; bits above it are zeroed
    assign keep_msb = 32'd8 + 32'(memtype[4:2]);

    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_mask
            localparam logic [31:0] BIT_IDX = 32'(gi);
            assign addr_mask[gi] = (keep_msb >= BIT_IDX);
        end
    endgenerate

    assign masked_addr = address & addr_mask;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

    assign session_start = test_mode && !test_mode_q && (state_q != LOGGING);
    assign fail_event    = (state_q == LOGGING) && error && !error_q;
    assign do_pop        = !empty_w && fail_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is kept
    assign do_push       = fail_event && !dup && (!full_w || do_pop);
    assign do_drop       = fail_event && !dup && full_w && !do_pop;

`ifdef MBIST_FAIL_LOG_DEDUP_EN
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  last_valid_q, last_valid_d;

    assign dup = last_valid_q && (last_addr_q == masked_addr);

    // Remember the last address actually pushed in this session
    always_comb begin
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
        if (session_start) begin
            last_valid_d = 1'b0;
        end else if (do_push) begin
            last_addr_d  = masked_addr;
            last_valid_d = 1'b1;
        end
    end

    // Last-address register, invalidated on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Next-state logic for the session FSM, FIFO pointers and counters
    always_comb begin
        state_d      = state_q;
        test_mode_d  = test_mode;
        error_d      = error;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fail_count_d = fail_count_q;
        overflow_d   = overflow_q;
        log_done_d   = log_done_q;

        if (session_start) begin
            state_d      = LOGGING;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fail_count_d = '0;
            overflow_d   = 1'b0;
            log_done_d   = 1'b0;
        end else begin
            if (state_q == LOGGING && (complete || force_terminate)) begin
                state_d    = DONE;
                log_done_d = 1'b1;
            end
            if (fail_event && (fail_count_q != '1)) begin
                fail_count_d = fail_count_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            test_mode_q  <= 1'b0;
            error_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fail_count_q <= '0;
            overflow_q   <= 1'b0;
            log_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            test_mode_q  <= test_mode_d;
            error_q      <= error_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fail_count_q <= fail_count_d;
            overflow_q   <= overflow_d;
            log_done_q   <= log_done_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr_q[IW-1:0]] <= masked_addr;
        end
    end

    assign fail_valid = !empty_w;
    assign fail_addr  = empty_w ? '0 : mem[rd_ptr_q[IW-1:0]];
    assign fail_count = fail_count_q;
    assign fifo_full  = full_w;
    assign fifo_empty = empty_w;
    assign overflow   = overflow_q;
    assign log_done   = log_done_q;

endmodule

// File: tb/tb_mbist_fail_log.sv
// tb_mbist_fail_log: table-driven address-mask vectors plus hand-written
// sequences for overflow, level-held error, session control and reset.
module tb_mbist_fail_log;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_mode;
    logic [4:0]  memtype;
    logic [15:0] address;
    logic        error;
    logic        complete;
    logic        force_terminate;
    logic        fail_ready;
    logic        fail_valid;
    logic [15:0] fail_addr;
    logic [15:0] fail_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
    logic        log_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mbist_fail_log #(.ADDR_WIDTH(16), .DEPTH(16), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .test_mode      (test_mode),
        .memtype        (memtype),
        .address        (address),
        .error          (error),
        .complete       (complete),
        .force_terminate(force_terminate),
        .fail_ready     (fail_ready),
        .fail_valid     (fail_valid),
        .fail_addr      (fail_addr),
        .fail_count     (fail_count),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .overflow       (overflow),
        .log_done       (log_done)
    );

    typedef struct {
        logic [4:0]  mt;
        logic [15:0] addr;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic start_session();
        test_mode = 1'b0;
        tick();
        test_mode = 1'b1;
        tick();
    endtask

    task automatic end_session();
        complete = 1'b1;
        tick();
        complete = 1'b0;
    endtask

    task automatic pulse_err(input logic [15:0] a);
        address = a;
        error   = 1'b1;
        tick();
        error   = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        fail_ready = 1'b1;
        tick();
        fail_ready = 1'b0;
    endtask

    initial begin
        // memtype, address, expected masked address
        vecs[0] = '{5'b00100, 16'h0203, 16'h0203};
        vecs[1] = '{5'b00100, 16'h0005, 16'h0005};
        vecs[2] = '{5'b00000, 16'hFFFF, 16'h01FF};
        vecs[3] = '{5'b00100, 16'hFFFF, 16'h03FF};
        vecs[4] = '{5'b01000, 16'hFFFF, 16'h07FF};
        vecs[5] = '{5'b10000, 16'hFFFF, 16'h1FFF};
        vecs[6] = '{5'b11000, 16'hFFFF, 16'h7FFF};
        vecs[7] = '{5'b11100, 16'hFFFF, 16'hFFFF};
        vecs[8] = '{5'b00111, 16'hABCD, 16'h03CD};

        rst_n = 1'b0; test_mode = 1'b0; memtype = '0; address = '0;
        error = 1'b0; complete = 1'b0; force_terminate = 1'b0; fail_ready = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst fail_valid", 32'(fail_valid), 32'd0);
        check("rst fail_addr", 32'(fail_addr), 32'd0);
        check("rst fail_count", 32'(fail_count), 32'd0);
        check("rst fifo_full", 32'(fifo_full), 32'd0);
        check("rst fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst log_done", 32'(log_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Error while IDLE is not an event
        pulse_err(16'h1234);
        check("idle no count", 32'(fail_count), 32'd0);
        check("idle empty", 32'(fifo_empty), 32'd1);

        // Table: one event per vector, head checked the cycle after, then popped
        start_session();
        for (int i = 0; i < 9; i++) begin
            memtype = vecs[i].mt;
            address = vecs[i].addr;
            error   = 1'b1;
            tick();
            error   = 1'b0;
            check($sformatf("vec%0d valid", i), 32'(fail_valid), 32'd1);
            check($sformatf("vec%0d addr", i), 32'(fail_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d count", i), 32'(fail_count), 32'(i + 1));
            pop_one();
            check($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'd1);
        end
        check("tbl fail_valid", 32'(fail_valid), 32'd0);

        // Two queued entries drained in order
        memtype = 5'b00100;
        pulse_err(16'h0203);
        pulse_err(16'h0005);
        check("two head", 32'(fail_addr), 32'h0203);
        pop_one();
        check("two second", 32'(fail_addr), 32'h0005);
        pop_one();
        check("two empty", 32'(fifo_empty), 32'd1);
        check("two valid", 32'(fail_valid), 32'd0);

        // Overflow: 18 events, no pops
        end_session();
        check("log_done after complete", 32'(log_done), 32'd1);
        start_session();
        check("restart count clr", 32'(fail_count), 32'd0);
        check("restart log_done clr", 32'(log_done), 32'd0);
        memtype = 5'b11100;
        for (int i = 0; i < 18; i++) pulse_err(16'h0100 + 16'(i));
        check("ovf full", 32'(fifo_full), 32'd1);
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf count", 32'(fail_count), 32'd18);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf drain%0d", i), 32'(fail_addr), 32'h0100 + 32'(i));
            pop_one();
        end
        check("ovf drained empty", 32'(fifo_empty), 32'd1);

        // Push and pop together while full: nothing dropped
        end_session();
        start_session();
        check("new session ovf clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) pulse_err(16'h0200 + 16'(i));
        check("pp full", 32'(fifo_full), 32'd1);
        address    = 16'hBEEF;
        error      = 1'b1;
        fail_ready = 1'b1;
        tick();
        error      = 1'b0;
        fail_ready = 1'b0;
        check("pp overflow", 32'(overflow), 32'd0);
        check("pp still full", 32'(fifo_full), 32'd1);
        check("pp count", 32'(fail_count), 32'd17);
        check("pp head", 32'(fail_addr), 32'h0201);
        for (int i = 0; i < 15; i++) pop_one();
        check("pp last", 32'(fail_addr), 32'hBEEF);
        pop_one();
        check("pp empty", 32'(fifo_empty), 32'd1);

        // Level-held error is one event
        end_session();
        start_session();
        address = 16'h0042;
        error   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        error   = 1'b0;
        tick();
        check("held count", 32'(fail_count), 32'd1);
        check("held head", 32'(fail_addr), 32'h0042);
        pop_one();
        check("held one entry", 32'(fifo_empty), 32'd1);

        // Event in the same cycle as complete is still logged
        address  = 16'h0077;
        error    = 1'b1;
        complete = 1'b1;
        tick();
        error    = 1'b0;
        complete = 1'b0;
        check("done log_done", 32'(log_done), 32'd1);
        check("done same-cycle count", 32'(fail_count), 32'd2);
        check("done same-cycle addr", 32'(fail_addr), 32'h0077);
        tick();
        // Events in DONE are ignored
        pulse_err(16'h0088);
        check("done ignore count", 32'(fail_count), 32'd2);
        // Session start discards leftover entries
        start_session();
        check("start count clr", 32'(fail_count), 32'd0);
        check("start log_done clr", 32'(log_done), 32'd0);
        check("start empty", 32'(fifo_empty), 32'd1);

        // force_terminate also ends the session
        force_terminate = 1'b1;
        tick();
        force_terminate = 1'b0;
        check("force_terminate done", 32'(log_done), 32'd1);

        // Duplicate-address sequence
        start_session();
        pulse_err(16'h0010);
        pulse_err(16'h0010);
        pulse_err(16'h0011);
        check("dedup count", 32'(fail_count), 32'd3);
        check("dedup head0", 32'(fail_addr), 32'h0010);
        pop_one();
`ifdef MBIST_FAIL_LOG_DEDUP_EN
        check("dedup head1", 32'(fail_addr), 32'h0011);
        pop_one();
`else
        check("dedup head1", 32'(fail_addr), 32'h0010);
        pop_one();
        check("dedup head2", 32'(fail_addr), 32'h0011);
        pop_one();
`endif
        check("dedup empty", 32'(fifo_empty), 32'd1);

        // Reset mid-session with 4 entries queued
        for (int i = 0; i < 4; i++) pulse_err(16'h0300 + 16'(i));
        check("pre-rst count", 32'(fail_count), 32'd7);
        rst_n     = 1'b0;
        test_mode = 1'b0;
        tick();
        rst_n     = 1'b1;
        check("mid rst fail_valid", 32'(fail_valid), 32'd0);
        check("mid rst fail_addr", 32'(fail_addr), 32'd0);
        check("mid rst fail_count", 32'(fail_count), 32'd0);
        check("mid rst fifo_full", 32'(fifo_full), 32'd0);
        check("mid rst fifo_empty", 32'(fifo_empty), 32'd1);
        check("mid rst overflow", 32'(overflow), 32'd0);
        check("mid rst log_done", 32'(log_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
